// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: operation request and per-destination result handshake bundle
interface alu_dispatch_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 32
);
  logic [3:0]            op_code;
  logic [XLEN-1:0]       input_A;
  logic [XLEN-1:0]       input_B;
  logic                  reg_out;
  logic                  mem_out;
  logic                  pc_jump;
  logic                  pc_cond;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  inputs_valid;
  logic                  inputs_ready;
  logic [XLEN-1:0]       reg_wr_data;
  logic [REG_ADDR_W-1:0] reg_wr_addr;
  logic                  reg_wr_data_valid;
  logic                  reg_wr_ack;
  logic [XLEN-1:0]       mem_wr_data;
  logic [MEM_ADDR_W-1:0] mem_wr_addr;
  logic                  mem_wr_data_valid;
  logic                  mem_wr_ack;
  logic [XLEN-1:0]       pc_branch_data;
  logic                  pc_branch_data_valid;
  logic                  pc_branch_data_ack;
  logic                  done;
  logic                  busy;
  modport master (
    output op_code, input_A, input_B, reg_out, mem_out, pc_jump, pc_cond,
           reg_addr, mem_addr, inputs_valid, reg_wr_ack, mem_wr_ack, pc_branch_data_ack,
    input  inputs_ready, reg_wr_data, reg_wr_addr, reg_wr_data_valid, mem_wr_data,
           mem_wr_addr, mem_wr_data_valid, pc_branch_data, pc_branch_data_valid, done, busy
  );
  modport slave (
    input  op_code, input_A, input_B, reg_out, mem_out, pc_jump, pc_cond,
           reg_addr, mem_addr, inputs_valid, reg_wr_ack, mem_wr_ack, pc_branch_data_ack,
    output inputs_ready, reg_wr_data, reg_wr_addr, reg_wr_data_valid, mem_wr_data,
           mem_wr_addr, mem_wr_data_valid, pc_branch_data, pc_branch_data_valid, done, busy
  );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: execute-stage ALU that hands its result to reg/mem/pc consumers
module alu_dispatch #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_dispatch_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, DISPATCH, DONE} state_t;
  state_t                state_q, state_d;
  logic [2:0]            mask_q, mask_d;
  logic [XLEN-1:0]       res_q, res_d, res;
  logic [REG_ADDR_W-1:0] raddr_q, raddr_d;
  logic [MEM_ADDR_W-1:0] maddr_q, maddr_d;
  logic [SW-1:0]         sh;
  logic                  take;
  assign sh   = bus.input_B[SW-1:0];
  assign take = bus.pc_jump & (~bus.pc_cond | (|res));
  // combinational ALU; reserved opcodes yield zero
  always_comb begin
    res = '0;
    case (bus.op_code)
      4'd0:    res = bus.input_A + bus.input_B;
      4'd1:    res = bus.input_A - bus.input_B;
      4'd2:    res = bus.input_A & bus.input_B;
      4'd3:    res = bus.input_A | bus.input_B;
      4'd4:    res = bus.input_A ^ bus.input_B;
      4'd5:    res = bus.input_A << sh;
      4'd6:    res = bus.input_A >> sh;
      4'd7:    res = $signed(bus.input_A) >>> sh;
      4'd8:    res = {{(XLEN-1){1'b0}}, $signed(bus.input_A) < $signed(bus.input_B)};
      4'd9:    res = {{(XLEN-1){1'b0}}, bus.input_A < bus.input_B};
      4'd10:   res = bus.input_B;
      default: res = '0;
    endcase
  end
  // capture on accept, then retire destinations as their acks arrive; mask bit {reg,mem,pc}
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    res_d   = res_q;
    raddr_d = raddr_q;
    maddr_d = maddr_q;
    case (state_q)
      IDLE: if (bus.inputs_valid) begin
        mask_d  = {bus.reg_out, bus.mem_out, take};
        res_d   = res;
        raddr_d = bus.reg_addr;
        maddr_d = bus.mem_addr;
        state_d = (|mask_d) ? DISPATCH : DONE;
      end
      DISPATCH: begin
        mask_d  = mask_q & ~{bus.reg_wr_ack, bus.mem_wr_ack, bus.pc_branch_data_ack};
        state_d = (|mask_d) ? DISPATCH : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and captured transaction registers; reset aborts any outstanding dispatch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      res_q   <= '0;
      raddr_q <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
      raddr_q <= raddr_d;
      maddr_q <= maddr_d;
    end
  end
  assign bus.inputs_ready         = state_q == IDLE;
  assign bus.busy                 = state_q != IDLE;
  assign bus.done                 = state_q == DONE;
  assign bus.reg_wr_data          = res_q;
  assign bus.reg_wr_addr          = raddr_q;
  assign bus.reg_wr_data_valid    = mask_q[2];
  assign bus.mem_wr_data          = res_q;
  assign bus.mem_wr_addr          = maddr_q;
  assign bus.mem_wr_data_valid    = mask_q[1];
  assign bus.pc_branch_data       = res_q;
  assign bus.pc_branch_data_valid = mask_q[0];
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed and randomized checks of alu_dispatch against a transaction model
module tb_alu_dispatch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   armed = 1'b0;
  bit   rand_ack = 1'b0;
  int   total = 0;
  int   passed = 0;
  always #5 clk = ~clk;

  alu_dispatch_if #(.XLEN(32), .REG_ADDR_W(5), .MEM_ADDR_W(32)) bus();
  alu_dispatch #(.XLEN(32), .REG_ADDR_W(5), .MEM_ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << s;
      4'd6:    return a >> s;
      4'd7:    return (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // transaction-level model: outstanding destinations plus a completion flag
  logic        m_r, m_m, m_p, m_done;
  logic [31:0] m_res, m_ma;
  logic [4:0]  m_ra;
  logic [31:0] m_calc;
  logic        m_take, m_busy, l_r, l_m, l_p;
  assign m_calc = ref_alu(bus.op_code, bus.input_A, bus.input_B);
  assign m_take = bus.pc_jump && (!bus.pc_cond || m_calc != 32'd0);
  assign m_busy = m_r || m_m || m_p || m_done;
  assign l_r = m_r && !bus.reg_wr_ack;
  assign l_m = m_m && !bus.mem_wr_ack;
  assign l_p = m_p && !bus.pc_branch_data_ack;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {m_r, m_m, m_p, m_done} <= 4'b0;
      m_res <= '0;
      m_ra  <= '0;
      m_ma  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && bus.inputs_valid) begin
        m_r    <= bus.reg_out;
        m_m    <= bus.mem_out;
        m_p    <= m_take;
        m_done <= !(bus.reg_out || bus.mem_out || m_take);
        m_res  <= m_calc;
        m_ra   <= bus.reg_addr;
        m_ma   <= bus.mem_addr;
      end else if (m_r || m_m || m_p) begin
        m_r    <= l_r;
        m_m    <= l_m;
        m_p    <= l_p;
        m_done <= !(l_r || l_m || l_p);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (reset && armed) begin
      chk("ready", bus.inputs_ready, !m_busy);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("reg_valid", bus.reg_wr_data_valid, m_r);
      chk("mem_valid", bus.mem_wr_data_valid, m_m);
      chk("pc_valid", bus.pc_branch_data_valid, m_p);
      if (m_r) begin
        chk("reg_data", bus.reg_wr_data, m_res);
        chk("reg_addr", bus.reg_wr_addr, m_ra);
      end
      if (m_m) begin
        chk("mem_data", bus.mem_wr_data, m_res);
        chk("mem_addr", bus.mem_wr_addr, m_ma);
      end
      if (m_p) chk("pc_data", bus.pc_branch_data, m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ack) begin
      bus.reg_wr_ack         = 1'($urandom_range(0, 1));
      bus.mem_wr_ack         = 1'($urandom_range(0, 1));
      bus.pc_branch_data_ack = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input logic m, input logic p, input logic c,
                       input logic [4:0] ra, input logic [31:0] ma);
    int n = 0;
    while (!bus.inputs_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.inputs_ready) chk("ready_timeout", bus.inputs_ready, 1);
    bus.op_code = op; bus.input_A = a; bus.input_B = b;
    bus.reg_out = r; bus.mem_out = m; bus.pc_jump = p; bus.pc_cond = c;
    bus.reg_addr = ra; bus.mem_addr = ma;
    bus.inputs_valid = 1'b1;
    tick();
    bus.inputs_valid = 1'b0;
  endtask

  task automatic run_reg(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv);
    do_op(op, a, b, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
    chk(name, bus.reg_wr_data, expv);
    bus.reg_wr_ack = 1'b1;
    tick();
    bus.reg_wr_ack = 1'b0;
    chk({name, "_done"}, bus.done, 1);
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.op_code = '0; bus.input_A = '0; bus.input_B = '0;
    bus.reg_out = 0; bus.mem_out = 0; bus.pc_jump = 0; bus.pc_cond = 0;
    bus.reg_addr = '0; bus.mem_addr = '0; bus.inputs_valid = 0;
    bus.reg_wr_ack = 0; bus.mem_wr_ack = 0; bus.pc_branch_data_ack = 0;
    repeat (3) tick();
    chk("rst_ready", bus.inputs_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valids", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.pc_branch_data_valid}, 0);
    chk("rst_data", bus.reg_wr_data, 0);
    reset = 1'b1;
    armed = 1'b1;
    tick();
    chk("pin_sub", ref_alu(4'd1, 32'd0, 32'd1), 32'hFFFFFFFF);
    chk("pin_sra", ref_alu(4'd7, 32'h80000000, 32'd33), 32'hC0000000);
    chk("pin_slt", ref_alu(4'd8, 32'hFFFFFFFF, 32'd1), 32'd1);
    chk("pin_sltu", ref_alu(4'd9, 32'hFFFFFFFF, 32'd1), 32'd0);

    do_op(4'd0, 32'd1, 32'd1, 1, 0, 0, 0, 5'd5, 32'd0);
    chk("add_valid", bus.reg_wr_data_valid, 1);
    chk("add_data", bus.reg_wr_data, 2);
    chk("add_addr", bus.reg_wr_addr, 5);
    chk("add_nodone", bus.done, 0);
    bus.reg_wr_ack = 1'b1;
    tick();
    bus.reg_wr_ack = 1'b0;
    chk("add_drop", bus.reg_wr_data_valid, 0);
    chk("add_done", bus.done, 1);
    tick();
    chk("add_pulse", bus.done, 0);
    chk("add_ready", bus.inputs_ready, 1);

    do_op(4'd0, 32'd2, 32'd2, 1, 1, 1, 0, 5'd3, 32'd7);
    chk("tri_valids", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.pc_branch_data_valid}, 3'b111);
    chk("tri_data", bus.mem_wr_data, 4);
    chk("tri_maddr", bus.mem_wr_addr, 7);
    bus.mem_wr_ack = 1'b1; tick(); bus.mem_wr_ack = 1'b0;
    chk("tri_mem", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.pc_branch_data_valid, bus.done}, 4'b1010);
    bus.pc_branch_data_ack = 1'b1; tick(); bus.pc_branch_data_ack = 1'b0;
    chk("tri_pc", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.pc_branch_data_valid, bus.done}, 4'b1000);
    bus.reg_wr_ack = 1'b1; tick(); bus.reg_wr_ack = 1'b0;
    chk("tri_reg", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.pc_branch_data_valid, bus.done}, 4'b0001);
    tick();

    run_reg("sub", 4'd1, 32'd0, 32'd1, 32'hFFFFFFFF);
    run_reg("sra", 4'd7, 32'h80000000, 32'd33, 32'hC0000000);
    run_reg("slt", 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1);
    run_reg("sltu", 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_reg("sll", 4'd5, 32'h1, 32'd36, 32'h10);
    run_reg("rsvd", 4'd13, 32'h5, 32'h5, 32'h0);

    do_op(4'd1, 32'd5, 32'd5, 0, 0, 1, 1, 5'd0, 32'd0);
    chk("nt_valid", bus.pc_branch_data_valid, 0);
    chk("nt_done", bus.done, 1);
    tick();
    chk("nt_pulse", bus.done, 0);
    chk("nt_ready", bus.inputs_ready, 1);
    do_op(4'd1, 32'd6, 32'd5, 0, 0, 1, 1, 5'd0, 32'd0);
    chk("tk_valid", bus.pc_branch_data_valid, 1);
    chk("tk_data", bus.pc_branch_data, 1);
    tick(); tick();
    chk("tk_hold", {bus.pc_branch_data_valid, bus.done}, 2'b10);
    bus.pc_branch_data_ack = 1'b1; tick(); bus.pc_branch_data_ack = 1'b0;
    chk("tk_done", bus.done, 1);
    tick();

    bus.reg_wr_ack = 1'b1;
    do_op(4'd3, 32'hF0, 32'h0F, 1, 0, 0, 0, 5'd2, 32'd0);
    chk("held_valid", bus.reg_wr_data_valid, 1);
    tick();
    bus.reg_wr_ack = 1'b0;
    chk("held_done", {bus.reg_wr_data_valid, bus.done}, 2'b01);
    tick();

    do_op(4'd0, 32'd3, 32'd4, 1, 0, 0, 0, 5'd9, 32'd0);
    bus.op_code = 4'd10; bus.input_B = 32'd99; bus.reg_addr = 5'd1; bus.inputs_valid = 1'b1;
    tick();
    chk("ign_ready", bus.inputs_ready, 0);
    chk("ign_data", bus.reg_wr_data, 7);
    tick();
    chk("ign_addr", bus.reg_wr_addr, 9);
    bus.inputs_valid = 1'b0;
    bus.reg_wr_ack = 1'b1; tick(); bus.reg_wr_ack = 1'b0;
    chk("ign_done", bus.done, 1);
    tick();

    do_op(4'd0, 32'd1, 32'd2, 1, 1, 0, 0, 5'd4, 32'd8);
    chk("ab_valid", bus.reg_wr_data_valid, 1);
    reset = 1'b0;
    #1;
    chk("ab_drop", {bus.reg_wr_data_valid, bus.mem_wr_data_valid, bus.busy}, 3'b000);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_nodone", bus.done, 0);
    end

    rand_ack = 1'b1;
    for (int i = 0; i < 300; i++)
      do_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom), $urandom);
    for (int n = 0; n < 100 && bus.busy; n++) tick();
    chk("drain", bus.busy, 0);
    rand_ack = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Parametrised execute-stage ALU with multi-destination result dispatch. It accepts one operation per transaction through a valid/ready handshake and computes an XLEN-bit result. It then offers that result to any combination of register-file, memory-write and PC-branch consumers, each with its own valid/ack handshake. It pulses `done` once every requested destination has acknowledged, and sits between decode/operand-fetch and the writeback/memory/fetch units.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `REG_ADDR_W`, 5: register address width.
- `MEM_ADDR_W`, 32: memory address width.
- `clk` input 1: clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `op_code` input 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B; 11–15 reserved, result 0.
- `input_A`, `input_B` input XLEN: operands.
- `reg_out`, `mem_out`, `pc_jump` input 1: destination request bits, any combination.
- `pc_cond` input 1: 1 = branch only if result ≠ 0; 0 = unconditional.
- `reg_addr` input REG_ADDR_W, `mem_addr` input MEM_ADDR_W: destination addresses.
- `inputs_valid` input 1, `inputs_ready` output 1: operation handshake.
- `reg_wr_data` output XLEN, `reg_wr_addr` output REG_ADDR_W, `reg_wr_data_valid` output 1, `reg_wr_ack` input 1.
- `mem_wr_data` output XLEN, `mem_wr_addr` output MEM_ADDR_W, `mem_wr_data_valid` output 1, `mem_wr_ack` input 1.
- `pc_branch_data` output XLEN, `pc_branch_data_valid` output 1, `pc_branch_data_ack` input 1.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: transaction outstanding.

## Operation
- States: IDLE, DISPATCH, DONE.
- IDLE: `inputs_ready`=1. On `inputs_valid`, the block registers the result, the addresses and a pending mask {reg,mem,pc}.
  - pc pending = `pc_jump` & (~`pc_cond` | result≠0).
  - Mask ≠ 0 → DISPATCH, with every pending valid asserted.
  - Mask = 0 → DONE.
- DISPATCH: each valid is held with data/addr stable until its ack is sampled high. That valid and its mask bit then clear at the same edge. When the last mask bit clears → DONE.
- DONE: `done`=1 for one cycle, then IDLE. `inputs_ready`=0 in DONE.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN.
  - Shifts use `input_B[$clog2(XLEN)-1:0]` only.
  - SLT is signed, SLTU unsigned; the result is zero-extended 0/1.
- Acks are ignored when the corresponding valid is low. `inputs_valid` is ignored when `inputs_ready`=0.
- Output data/addr are don't-care while their valid is low, but hold their last value (no X).

## Timing
- Reset (async assert): all valids, `done`, `busy` = 0; `inputs_ready` = 1; data/addr = 0; state IDLE; pending mask cleared. Reset asserted mid-DISPATCH aborts the transaction with no `done`.
- Accept at edge N → valids high from edge N to the edge after the ack. Minimum single-destination transaction: accept N, ack sampled N+1, `done` high N+1..N+2, `inputs_ready` high again from N+2.
- Multiple destinations ack independently in any order or simultaneously. `done` follows the edge where the final ack is sampled.
- Zero-destination or not-taken conditional branch: `done` high during cycle N+1 only.
- `busy` = state ≠ IDLE.
- Ack held high continuously is legal; it completes the destination at the first edge its valid is high.

## Test plan
- Reset held 3 cycles → all valids, `done`, `busy` = 0; `inputs_ready` = 1.
- ADD A=1, B=1, `reg_out`, `reg_addr`=5 → next cycle `reg_wr_data_valid`=1, data=2, addr=5, `done`=0. Ack → valid 0, `done`=1 for one cycle.
- ADD A=2, B=2 with `reg_out`+`mem_out`+`pc_jump`, `mem_addr`=7 → all three valids, data 4.
  - Ack mem, then pc, then reg on separate cycles; each valid drops individually.
  - `done` comes only after the reg ack.
- SUB A=0, B=1 → 0xFFFFFFFF. SRA A=0x80000000, B=33 → 0xC0000000. SLT A=-1, B=1 → 1. SLTU same operands → 0.
- `pc_cond`=1, SUB A=5, B=5 (result 0) with `pc_jump` only → no valid; `done` pulses next cycle. Same with A=6 → `pc_branch_data`=1, valid held until ack.
- `inputs_valid` asserted while DISPATCH → ignored, `inputs_ready`=0. Reset asserted mid-DISPATCH → valids drop immediately and no `done` is produced.
